// File: rtl/frame_sched_pkg.sv
// Shared encodings for the frame bank scheduler: per-bank lifecycle state
// and the producer/consumer FSM states.
package frame_sched_pkg;

   // Lifecycle of one BRAM frame bank.
   typedef enum logic [1:0] {
      BANK_FREE      = 2'd0,
      BANK_FILLING   = 2'd1,
      BANK_FULL      = 2'd2,
      BANK_STREAMING = 2'd3
   } bank_state_e;

   // Producer (undistort write engine) side.
   typedef enum logic {
      P_IDLE = 1'b0,
      P_FILL = 1'b1
   } prod_state_e;

   // Consumer (BRAM-to-AXI-stream reader) side.
   typedef enum logic {
      C_IDLE = 1'b0,
      C_BUSY = 1'b1
   } cons_state_e;

endpackage

// File: rtl/frame_bank_scheduler_if.sv
// Handshake and status bundle between the scheduler (master) and the
// write engine / stream reader environment (slave).
interface frame_bank_scheduler_if #(
   parameter int unsigned NUM_BANKS = 2,
   parameter int unsigned BANK_W    = 2,
   parameter int unsigned CNT_W     = 16
);
   logic                 enable;
   logic                 prod_req;
   logic                 prod_start;
   logic [BANK_W-1:0]    prod_bank;
   logic                 prod_done;
   logic                 stream_start;
   logic [BANK_W-1:0]    stream_bank;
   logic                 stream_done;
   logic [NUM_BANKS-1:0] free_banks;
   logic [CNT_W-1:0]     frame_count;
   logic [CNT_W-1:0]     drop_count;
   logic                 timeout_err;
   logic                 protocol_err;

   modport master (
      input  enable, prod_req, prod_done, stream_done,
      output prod_start, prod_bank, stream_start, stream_bank,
      output free_banks, frame_count, drop_count, timeout_err, protocol_err
   );

   modport slave (
      output enable, prod_req, prod_done, stream_done,
      input  prod_start, prod_bank, stream_start, stream_bank,
      input  free_banks, frame_count, drop_count, timeout_err, protocol_err
   );
endinterface

// File: rtl/bank_index_fifo.sv
// Small synchronous FIFO of bank indices. Holds filled banks in fill order.
// A push while full (and not popping) is dropped; the parent flags it.
module bank_index_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 2
) (
   input  logic             ACLK,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic             o_empty,
   output logic             o_full,
   output logic [WIDTH-1:0] o_head
);
   localparam int unsigned     PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned     CNT_BITS = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [CNT_BITS-1:0] r_count;
   logic                w_do_push;
   logic                w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_BITS'(DEPTH));
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   // A simultaneous pop frees the slot, so a push into a full FIFO is still legal then.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Storage; contents are don't-care until written, so no reset.
   always_ff @(posedge ACLK) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointer and occupancy bookkeeping with wrap at DEPTH (DEPTH may be 3).
   always_ff @(posedge ACLK or negedge rst) begin
      if (!rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PTR_W'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CNT_BITS'(1);
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - CNT_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/frame_bank_scheduler.sv
// Multi-bank frame buffer sequencer. Grants free banks to the write engine,
// queues filled banks in fill order, kicks the stream reader per bank and
// reclaims banks on completion or watchdog expiry.
module frame_bank_scheduler
   import frame_sched_pkg::*;
#(
   parameter int unsigned NUM_BANKS      = 2,
   parameter int unsigned BANK_W         = 2,
   parameter bit          DROP_OLDEST    = 1'b1,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd200000,
   parameter int unsigned CNT_W          = 16
) (
   input  logic                  ACLK,
   input  logic                  rst,
   frame_bank_scheduler_if.master bus
);
   // Table sized to the full index space so any BANK_W index is in range.
   localparam int unsigned NUM_SLOTS = 1 << BANK_W;

   bank_state_e          r_bank_st   [NUM_SLOTS];
   bank_state_e          w_bank_st_d [NUM_SLOTS];

   prod_state_e          r_p_state, w_p_state_d;
   cons_state_e          r_c_state, w_c_state_d;

   logic                 r_prod_start, w_prod_start_d;
   logic [BANK_W-1:0]    r_prod_bank, w_prod_bank_d;
   logic                 r_stream_start, w_stream_start_d;
   logic [BANK_W-1:0]    r_stream_bank, w_stream_bank_d;
   logic [31:0]          r_wdog, w_wdog_d;

   logic [CNT_W-1:0]     r_frame_cnt, w_frame_cnt_d;
   logic [CNT_W-1:0]     r_drop_cnt, w_drop_cnt_d;
   logic                 r_timeout_err, w_timeout_err_d;
   logic                 r_protocol_err, w_protocol_err_d;

   logic                 w_any_free;
   logic [BANK_W-1:0]    w_free_idx;
   logic [NUM_BANKS-1:0] w_free_map;

   logic                 w_p_take, w_p_drop_pop, w_p_push, w_p_err;
   logic                 w_c_pop, w_c_done, w_c_timeout, w_c_err;

   logic                 w_fifo_pop, w_fifo_empty, w_fifo_full, w_fifo_ovf;
   logic [BANK_W-1:0]    w_fifo_head;

   assign w_fifo_pop = w_c_pop || w_p_drop_pop;
   assign w_fifo_ovf = w_p_push && w_fifo_full && !w_fifo_pop;

   bank_index_fifo #(
      .DEPTH (NUM_BANKS),
      .WIDTH (BANK_W)
   ) u_ready_q (
      .ACLK        (ACLK),
      .rst         (rst),
      .i_push      (w_p_push),
      .i_push_data (r_prod_bank),
      .i_pop       (w_fifo_pop),
      .o_empty     (w_fifo_empty),
      .o_full      (w_fifo_full),
      .o_head      (w_fifo_head)
   );

   // Free bitmap and lowest free index, scanned high to low so the lowest wins.
   always_comb begin
      w_any_free = 1'b0;
      w_free_idx = '0;
      w_free_map = '0;
      for (int i = NUM_BANKS - 1; i >= 0; i--) begin
         if (r_bank_st[i] == BANK_FREE) begin
            w_any_free    = 1'b1;
            w_free_idx    = BANK_W'(i);
            w_free_map[i] = 1'b1;
         end
      end
   end

   // Producer FSM next state: grant a free bank, else steal the oldest queued one.
   always_comb begin
      w_p_state_d    = r_p_state;
      w_prod_start_d = 1'b0;
      w_prod_bank_d  = r_prod_bank;
      w_p_take       = 1'b0;
      w_p_drop_pop   = 1'b0;
      w_p_push       = 1'b0;
      w_p_err        = 1'b0;
      case (r_p_state)
         P_IDLE: begin
            if (bus.enable && bus.prod_req) begin
               if (w_any_free) begin
                  w_p_take      = 1'b1;
                  w_prod_bank_d = w_free_idx;
               end else if (DROP_OLDEST && !w_fifo_empty && !w_c_pop) begin
                  // Consumer pop has priority; the drop retries next cycle.
                  w_p_take      = 1'b1;
                  w_p_drop_pop  = 1'b1;
                  w_prod_bank_d = w_fifo_head;
               end
            end
            if (w_p_take) begin
               w_prod_start_d = 1'b1;
               w_p_state_d    = P_FILL;
            end
            w_p_err = bus.prod_done;
         end
         P_FILL: begin
            if (bus.prod_done) begin
               w_p_push    = 1'b1;
               w_p_state_d = P_IDLE;
            end
         end
         default: w_p_state_d = P_IDLE;
      endcase
   end

   // Consumer FSM next state: start the oldest filled bank, finish or time out.
   always_comb begin
      w_c_state_d      = r_c_state;
      w_stream_start_d = 1'b0;
      w_stream_bank_d  = r_stream_bank;
      w_wdog_d         = r_wdog;
      w_c_pop          = 1'b0;
      w_c_done         = 1'b0;
      w_c_timeout      = 1'b0;
      w_c_err          = 1'b0;
      case (r_c_state)
         C_IDLE: begin
            if (bus.enable && !w_fifo_empty) begin
               w_c_pop          = 1'b1;
               w_stream_start_d = 1'b1;
               w_stream_bank_d  = w_fifo_head;
               w_wdog_d         = '0;
               w_c_state_d      = C_BUSY;
            end
            w_c_err = bus.stream_done;
         end
         C_BUSY: begin
            if (bus.stream_done) begin
               w_c_done    = 1'b1;
               w_c_state_d = C_IDLE;
            end else if ((TIMEOUT_CYCLES != 32'd0) &&
                         (r_wdog == TIMEOUT_CYCLES - 32'd1)) begin
               // r_wdog counts busy cycles already elapsed; this is the last allowed one.
               w_c_timeout = 1'b1;
               w_c_state_d = C_IDLE;
            end else begin
               w_wdog_d = r_wdog + 32'd1;
            end
         end
         default: w_c_state_d = C_IDLE;
      endcase
   end

   // Bank table update; the events in one cycle always touch distinct banks.
   always_comb begin
      w_bank_st_d = r_bank_st;
      if (w_p_take) begin
         w_bank_st_d[w_prod_bank_d] = BANK_FILLING;
      end
      if (w_p_push) begin
         w_bank_st_d[r_prod_bank] = BANK_FULL;
      end
      if (w_c_pop) begin
         w_bank_st_d[w_fifo_head] = BANK_STREAMING;
      end
      if (w_c_done || w_c_timeout) begin
         w_bank_st_d[r_stream_bank] = BANK_FREE;
      end
   end

   // Statistics and sticky error flags.
   always_comb begin
      w_frame_cnt_d    = r_frame_cnt;
      w_drop_cnt_d     = r_drop_cnt;
      w_timeout_err_d  = r_timeout_err || w_c_timeout;
      w_protocol_err_d = r_protocol_err || w_p_err || w_c_err || w_fifo_ovf;
      if (w_c_done) begin
         w_frame_cnt_d = r_frame_cnt + CNT_W'(1);
      end
      if (w_p_drop_pop && (r_drop_cnt != {CNT_W{1'b1}})) begin
         w_drop_cnt_d = r_drop_cnt + CNT_W'(1);
      end
   end

   // FSM state and handshake output registers.
   always_ff @(posedge ACLK or negedge rst) begin
      if (!rst) begin
         r_p_state      <= P_IDLE;
         r_c_state      <= C_IDLE;
         r_prod_start   <= 1'b0;
         r_prod_bank    <= '0;
         r_stream_start <= 1'b0;
         r_stream_bank  <= '0;
         r_wdog         <= '0;
      end else begin
         r_p_state      <= w_p_state_d;
         r_c_state      <= w_c_state_d;
         r_prod_start   <= w_prod_start_d;
         r_prod_bank    <= w_prod_bank_d;
         r_stream_start <= w_stream_start_d;
         r_stream_bank  <= w_stream_bank_d;
         r_wdog         <= w_wdog_d;
      end
   end

   // Per-bank lifecycle registers.
   always_ff @(posedge ACLK or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_bank_st[i] <= BANK_FREE;
         end
      end else begin
         r_bank_st <= w_bank_st_d;
      end
   end

   // Statistics registers.
   always_ff @(posedge ACLK or negedge rst) begin
      if (!rst) begin
         r_frame_cnt    <= '0;
         r_drop_cnt     <= '0;
         r_timeout_err  <= 1'b0;
         r_protocol_err <= 1'b0;
      end else begin
         r_frame_cnt    <= w_frame_cnt_d;
         r_drop_cnt     <= w_drop_cnt_d;
         r_timeout_err  <= w_timeout_err_d;
         r_protocol_err <= w_protocol_err_d;
      end
   end

   assign bus.prod_start   = r_prod_start;
   assign bus.prod_bank    = r_prod_bank;
   assign bus.stream_start = r_stream_start;
   assign bus.stream_bank  = r_stream_bank;
   assign bus.free_banks   = w_free_map;
   assign bus.frame_count  = r_frame_cnt;
   assign bus.drop_count   = r_drop_cnt;
   assign bus.timeout_err  = r_timeout_err;
   assign bus.protocol_err = r_protocol_err;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Randomized bench: instance 0 uses drop-oldest, instance 1 stalls. Both are
// compared every cycle against a queue-based reference model of the bank rules.
module tb_frame_bank_scheduler;
   localparam int NB = 2;
   localparam int BW = 2;
   localparam int CW = 3;
   localparam int TO = 20;
   localparam int CMAX = (1 << CW) - 1;

   localparam int FREE   = 0;
   localparam int FILL   = 1;
   localparam int QUEUED = 2;
   localparam int STREAM = 3;

   logic ACLK = 1'b0;
   logic rst;
   always #5 ACLK = ~ACLK;

   logic          en    [2];
   logic          req   [2];
   logic          pdone [2];
   logic          sdone [2];
   logic          o_pstart [2];
   logic [BW-1:0] o_pbank  [2];
   logic          o_sstart [2];
   logic [BW-1:0] o_sbank  [2];
   logic [NB-1:0] o_free   [2];
   logic [CW-1:0] o_fcnt   [2];
   logic [CW-1:0] o_dcnt   [2];
   logic          o_terr   [2];
   logic          o_perr   [2];

   for (genvar g = 0; g < 2; g++) begin : g_inst
      frame_bank_scheduler_if #(.NUM_BANKS(NB), .BANK_W(BW), .CNT_W(CW)) u_if ();

      assign u_if.enable      = en[g];
      assign u_if.prod_req    = req[g];
      assign u_if.prod_done   = pdone[g];
      assign u_if.stream_done = sdone[g];
      assign o_pstart[g]      = u_if.prod_start;
      assign o_pbank[g]       = u_if.prod_bank;
      assign o_sstart[g]      = u_if.stream_start;
      assign o_sbank[g]       = u_if.stream_bank;
      assign o_free[g]        = u_if.free_banks;
      assign o_fcnt[g]        = u_if.frame_count;
      assign o_dcnt[g]        = u_if.drop_count;
      assign o_terr[g]        = u_if.timeout_err;
      assign o_perr[g]        = u_if.protocol_err;

      frame_bank_scheduler #(
         .NUM_BANKS      (NB),
         .BANK_W         (BW),
         .DROP_OLDEST    (g == 0),
         .TIMEOUT_CYCLES (32'd20),
         .CNT_W          (CW)
      ) u_dut (
         .ACLK (ACLK),
         .rst  (rst),
         .bus  (u_if.master)
      );
   end

   // Reference model state, one set per instance.
   int bst [2][NB];
   int q   [2][NB];
   int qn  [2];
   bit m_pfill [2], m_pstart [2], m_cbusy [2], m_sstart [2], m_terr [2], m_perr [2];
   int m_pbank [2], m_sbank [2], m_busy [2], m_fcnt [2], m_dcnt [2];

   int n_checks = 0;
   int n_fail   = 0;
   int sdiv     = 10;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset(input int k);
      for (int b = 0; b < NB; b++) bst[k][b] = FREE;
      qn[k] = 0;
      m_pfill[k] = 0; m_pstart[k] = 0; m_cbusy[k] = 0; m_sstart[k] = 0;
      m_terr[k] = 0; m_perr[k] = 0;
      m_pbank[k] = 0; m_sbank[k] = 0; m_busy[k] = 0; m_fcnt[k] = 0; m_dcnt[k] = 0;
   endtask

   // One clock edge of the bank rules, decided from the state before the edge.
   task automatic model_step(input int k);
      int  lowest, gb, done_bank, head;
      bit  pop_c, grant, drop, fill_done;
      lowest = -1;
      for (int b = NB - 1; b >= 0; b--) if (bst[k][b] == FREE) lowest = b;
      pop_c = en[k] && !m_cbusy[k] && (qn[k] > 0);
      grant = 0; drop = 0; gb = 0; head = 0;
      if (!m_pfill[k] && en[k] && req[k]) begin
         if (lowest >= 0) begin
            grant = 1; gb = lowest;
         end else if (k == 0 && qn[k] > 0 && !pop_c) begin
            grant = 1; drop = 1; gb = q[k][0];
         end
      end
      fill_done = m_pfill[k] && pdone[k];
      done_bank = m_pbank[k];
      if ((pdone[k] && !m_pfill[k]) || (sdone[k] && !m_cbusy[k])) m_perr[k] = 1;
      m_pstart[k] = 0;
      m_sstart[k] = 0;
      if (m_cbusy[k]) begin
         if (sdone[k]) begin
            bst[k][m_sbank[k]] = FREE;
            m_fcnt[k] = (m_fcnt[k] + 1) % (CMAX + 1);
            m_cbusy[k] = 0;
         end else if (m_busy[k] == TO) begin
            bst[k][m_sbank[k]] = FREE;
            m_terr[k] = 1;
            m_cbusy[k] = 0;
         end else begin
            m_busy[k]++;
         end
      end
      if (fill_done) begin
         bst[k][done_bank] = QUEUED;
         m_pfill[k] = 0;
      end
      if (pop_c || drop) begin
         head = q[k][0];
         for (int i = 0; i < NB - 1; i++) q[k][i] = q[k][i+1];
         qn[k]--;
      end
      if (pop_c) begin
         bst[k][head] = STREAM;
         m_cbusy[k] = 1; m_sbank[k] = head; m_sstart[k] = 1; m_busy[k] = 1;
      end
      if (drop && m_dcnt[k] < CMAX) m_dcnt[k]++;
      if (grant) begin
         bst[k][gb] = FILL;
         m_pfill[k] = 1; m_pbank[k] = gb; m_pstart[k] = 1;
      end
      if (fill_done) begin
         q[k][qn[k]] = done_bank;
         qn[k]++;
      end
   endtask

   task automatic check_outputs(input int k);
      string       p;
      logic [31:0] fm;
      p  = (k == 0) ? "drop" : "stall";
      fm = '0;
      for (int b = 0; b < NB; b++) if (bst[k][b] == FREE) fm[b] = 1'b1;
      check_eq({p, ".prod_start"}, 32'(o_pstart[k]), 32'(m_pstart[k]));
      if (m_pfill[k]) check_eq({p, ".prod_bank"}, 32'(o_pbank[k]), m_pbank[k]);
      check_eq({p, ".stream_start"}, 32'(o_sstart[k]), 32'(m_sstart[k]));
      if (m_cbusy[k]) check_eq({p, ".stream_bank"}, 32'(o_sbank[k]), m_sbank[k]);
      check_eq({p, ".free_banks"}, 32'(o_free[k]), fm);
      check_eq({p, ".frame_count"}, 32'(o_fcnt[k]), m_fcnt[k]);
      check_eq({p, ".drop_count"}, 32'(o_dcnt[k]), m_dcnt[k]);
      check_eq({p, ".timeout_err"}, 32'(o_terr[k]), 32'(m_terr[k]));
      check_eq({p, ".protocol_err"}, 32'(o_perr[k]), 32'(m_perr[k]));
   endtask

   task automatic check_reset_values(input int k);
      check_eq("reset.prod_bank", 32'(o_pbank[k]), 0);
      check_eq("reset.stream_bank", 32'(o_sbank[k]), 0);
      check_eq("reset.free_banks", 32'(o_free[k]), (1 << NB) - 1);
      check_outputs(k);
   endtask

   // Phase 1 answers done only for work in flight; phase 2 adds stray pulses.
   task automatic drive(input int k, input int phase);
      en[k]  = ($urandom_range(9) != 0);
      req[k] = ($urandom_range(9) < 8);
      if (phase == 2) begin
         pdone[k] = ($urandom_range(5) == 0);
         sdone[k] = ($urandom_range(6) == 0);
      end else begin
         pdone[k] = m_pfill[k] && ($urandom_range(3) == 0);
         sdone[k] = m_cbusy[k] && ($urandom_range(sdiv) == 0);
      end
   endtask

   task automatic run_cycles(input int n, input int phase);
      for (int c = 0; c < n; c++) begin
         if (c % 150 == 0) sdiv = $urandom_range(30, 1);
         @(posedge ACLK);
         model_step(0);
         model_step(1);
         @(negedge ACLK);
         check_outputs(0);
         check_outputs(1);
         drive(0, phase);
         drive(1, phase);
      end
   endtask

   initial begin
      bit found;
      for (int k = 0; k < 2; k++) begin
         en[k] = 1'b0; req[k] = 1'b0; pdone[k] = 1'b0; sdone[k] = 1'b0;
         model_reset(k);
      end
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (3) @(negedge ACLK);
      check_reset_values(0);
      check_reset_values(1);
      rst = 1'b1;

      run_cycles(2500, 1);
      run_cycles(600, 2);

      // Reset asynchronously while instance 0 is streaming.
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         run_cycles(1, 1);
         if (m_cbusy[0]) found = 1;
      end
      check_eq("mid_reset.reach_busy", 32'(found), 1);
      #2 rst = 1'b0;
      #1;
      model_reset(0);
      model_reset(1);
      check_reset_values(0);
      check_reset_values(1);
      @(negedge ACLK);
      for (int k = 0; k < 2; k++) begin
         en[k] = 1'b1; req[k] = 1'b1; pdone[k] = 1'b0; sdone[k] = 1'b0;
      end
      rst = 1'b1;

      run_cycles(2500, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
